// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: field widths, control-flow opcodes,
// branch-condition encoding and the decoder used to classify each fetched word.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 12;
  localparam int FETCH_INSTR_W = 19;

  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [4:0] OP_JSR    = 5'b11100;
  localparam logic [4:0] OP_JMP    = 5'b11101;
  localparam logic [4:0] OP_RET    = 5'b11110;

  typedef enum logic [1:0] {
    COND_Z  = 2'b00,
    COND_NZ = 2'b01,
    COND_C  = 2'b10,
    COND_NC = 2'b11
  } br_cond_e;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    JMP,
    JSR,
    RET
  } cf_kind_e;

  function automatic cf_kind_e decode_kind(input logic [FETCH_INSTR_W-1:0] instr);
    cf_kind_e kind;
    case (instr[18:14])
      OP_JSR:  kind = JSR;
      OP_JMP:  kind = JMP;
      OP_RET:  kind = RET;
      default: kind = (instr[18:16] == OP_BRANCH) ? BR : SEQ;
    endcase
    return kind;
  endfunction

  function automatic logic cond_met(input br_cond_e cond, input logic z, input logic c);
    logic met;
    case (cond)
      COND_Z:  met = z;
      COND_NZ: met = ~z;
      COND_C:  met = c;
      default: met = ~c;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Hardware return-address stack (LIFO). SP counts occupied entries; pushes
// when full and pops when empty are ignored here and reported by the caller.
module return_stack
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int RS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] r_mem [RS_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_push_idx;

  assign full       = (r_sp == SP_W'(RS_DEPTH));
  assign empty      = (r_sp == '0);
  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_push_idx = r_sp[IDX_W-1:0];
  assign top_data   = r_mem[w_top_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push && !full) begin
      r_mem[w_push_idx] <= push_data;
      r_sp              <= r_sp + SP_W'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and next-address logic: resolves branches, JMP, JSR and RET
// locally each cycle and registers the next PC on the rising edge.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int INSTR_W  = FETCH_INSTR_W,
  parameter int RS_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               zero_flag,
  input  logic               carry_flag,
  output logic [ADDR_W-1:0]  address,
  output logic               redirect,
  output logic               stack_error
);

  logic [ADDR_W-1:0]        r_pc;
  logic                     r_stack_error;
  logic [ADDR_W-1:0]        w_pc_plus1;
  logic [ADDR_W-1:0]        w_next_pc;
  logic [ADDR_W-1:0]        w_jump_target;
  logic [ADDR_W-1:0]        w_top;
  logic signed [7:0]        w_br_off8;
  logic signed [ADDR_W-1:0] w_br_offset;
  cf_kind_e                 w_kind;
  logic                     w_taken;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_stack_fault;

  assign w_kind        = decode_kind(instruction);
  assign w_taken       = cond_met(br_cond_e'(instruction[15:14]), zero_flag, carry_flag);
  assign w_pc_plus1    = r_pc + ADDR_W'(1);
  assign w_jump_target = ADDR_W'(instruction[11:0]);
  assign w_br_off8     = instruction[7:0];
  assign w_br_offset   = ADDR_W'(w_br_off8);

  always_comb begin
    w_next_pc     = w_pc_plus1;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_stack_fault = 1'b0;
    case (w_kind)
      BR: begin
        if (w_taken) w_next_pc = w_pc_plus1 + $unsigned(w_br_offset);
      end
      JMP: w_next_pc = w_jump_target;
      JSR: begin
        // An overflowing call still jumps; only the return address is lost.
        w_next_pc     = w_jump_target;
        w_push        = ~w_full;
        w_stack_fault = w_full;
      end
      RET: begin
        if (!w_empty) begin
          w_next_pc = w_top;
          w_pop     = 1'b1;
        end else begin
          w_stack_fault = 1'b1;
        end
      end
      default: ;
    endcase
  end

  return_stack #(
    .ADDR_W   (ADDR_W),
    .RS_DEPTH (RS_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push & ~stall),
    .pop       (w_pop & ~stall),
    .push_data (w_pc_plus1),
    .top_data  (w_top),
    .full      (w_full),
    .empty     (w_empty)
  );

  // PC register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= '0;
      r_stack_error <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (w_stack_fault) r_stack_error <= 1'b1;
    end
  end

  assign address     = r_pc;
  assign stack_error = r_stack_error;
  assign redirect    = ~stall & (w_next_pc != w_pc_plus1);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed control-flow scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch rules.
module tb_fetch_unit;

  localparam int ADDR_W   = 12;
  localparam int INSTR_W  = 19;
  localparam int RS_DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               stall = 1'b0;
  logic [INSTR_W-1:0] instruction = '0;
  logic               zero_flag = 1'b0;
  logic               carry_flag = 1'b0;
  logic [ADDR_W-1:0]  address;
  logic               redirect;
  logic               stack_error;

  int checks   = 0;
  int failures = 0;

  int m_pc  = 0;
  bit m_err = 1'b0;
  int m_stk[$];

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RS_DEPTH (RS_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .instruction (instruction),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .address     (address),
    .redirect    (redirect),
    .stack_error (stack_error)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] f_br(input int cond, input int off);
    logic [1:0] c;
    logic [7:0] o;
    c = cond[1:0];
    o = off[7:0];
    return {3'b101, c, 6'b000000, o};
  endfunction

  function automatic logic [18:0] f_jmp(input int a);
    logic [11:0] t;
    t = a[11:0];
    return {5'b11101, 2'b00, t};
  endfunction

  function automatic logic [18:0] f_jsr(input int a);
    logic [11:0] t;
    t = a[11:0];
    return {5'b11100, 2'b00, t};
  endfunction

  function automatic logic [18:0] f_ret();
    return {5'b11110, 14'd0};
  endfunction

  // One fetch cycle: drive at posedge+1, sample redirect, advance the model, end at posedge+1.
  task automatic cyc(input logic [18:0] ins, input logic z, input logic c, input logic st,
                     output logic red_o, output logic red_e);
    int nxt;
    int off;
    bit take;
    instruction = ins;
    zero_flag   = z;
    carry_flag  = c;
    stall       = st;
    #1;
    red_o = redirect;
    nxt = (m_pc + 1) % 4096;
    if (!st) begin
      if (ins[18:14] == 5'b11100) begin
        if (m_stk.size() < RS_DEPTH) m_stk.push_back((m_pc + 1) % 4096);
        else m_err = 1'b1;
        nxt = int'(ins[11:0]);
      end else if (ins[18:14] == 5'b11101) begin
        nxt = int'(ins[11:0]);
      end else if (ins[18:14] == 5'b11110) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else m_err = 1'b1;
      end else if (ins[18:16] == 3'b101) begin
        case (ins[15:14])
          2'b00:   take = z;
          2'b01:   take = !z;
          2'b10:   take = c;
          default: take = !c;
        endcase
        off = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
        if (take) nxt = (m_pc + 1 + off) & 4095;
      end
    end
    red_e = !st && (nxt != (m_pc + 1) % 4096);
    @(posedge clk);
    #1;
    if (!st) m_pc = nxt;
    stall = 1'b0;
  endtask

  task automatic test_reset(input logic during_stall);
    stall = during_stall;
    instruction = f_jmp(12'h7AB);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (address !== 12'd0) begin
      failures++;
      $display("FAIL reset_address actual=%0d required=0", address);
    end
    checks++;
    if (stack_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_stack_error actual=%b required=0", stack_error);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall = 1'b0;
    instruction = '0;
    m_pc = 0;
    m_err = 1'b0;
    m_stk.delete();
    checks++;
    if (address !== 12'd0) begin
      failures++;
      $display("FAIL first_fetch actual=%0d required=0", address);
    end
  endtask

  task automatic test_sequential();
    logic ro, re;
    for (int i = 0; i < 3; i++) begin
      cyc('0, 1'b1, 1'b1, 1'b0, ro, re);
      checks++;
      if (ro !== 1'b0) begin
        failures++;
        $display("FAIL seq_redirect step=%0d actual=%b required=0", i, ro);
      end
      checks++;
      if (address !== 12'(i + 1)) begin
        failures++;
        $display("FAIL seq_address step=%0d actual=%0d required=%0d", i, address, i + 1);
      end
    end
  endtask

  task automatic test_branches();
    logic ro, re;
    cyc(f_br(0, 13), 1'b1, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd17 || ro !== 1'b1) begin
      failures++;
      $display("FAIL bz_taken addr=%0d redir=%b required addr=17 redir=1", address, ro);
    end
    cyc(f_jmp(3), 1'b0, 1'b0, 1'b0, ro, re);
    cyc(f_br(0, 13), 1'b0, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd4 || ro !== 1'b0) begin
      failures++;
      $display("FAIL bz_not_taken addr=%0d redir=%b required addr=4 redir=0", address, ro);
    end
    cyc(f_jmp(10), 1'b0, 1'b0, 1'b0, ro, re);
    cyc(f_br(3, 2), 1'b1, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd13 || ro !== 1'b1) begin
      failures++;
      $display("FAIL bnc_taken addr=%0d redir=%b required addr=13 redir=1", address, ro);
    end
    cyc(f_jmp(10), 1'b0, 1'b0, 1'b0, ro, re);
    cyc(f_br(3, 2), 1'b0, 1'b1, 1'b0, ro, re);
    checks++;
    if (address !== 12'd11 || ro !== 1'b0) begin
      failures++;
      $display("FAIL bnc_not_taken addr=%0d redir=%b required addr=11 redir=0", address, ro);
    end
  endtask

  task automatic test_wrap();
    logic ro, re;
    cyc(f_jmp(20), 1'b0, 1'b0, 1'b0, ro, re);
    cyc(f_br(1, 8'hFE), 1'b0, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd19 || ro !== 1'b1) begin
      failures++;
      $display("FAIL bnz_negative addr=%0d redir=%b required addr=19 redir=1", address, ro);
    end
    cyc(f_jmp(4095), 1'b0, 1'b0, 1'b0, ro, re);
    cyc('0, 1'b0, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd0 || ro !== 1'b0) begin
      failures++;
      $display("FAIL seq_wrap addr=%0d redir=%b required addr=0 redir=0", address, ro);
    end
    cyc(f_jmp(4094), 1'b0, 1'b0, 1'b0, ro, re);
    cyc(f_br(0, 5), 1'b1, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd4 || ro !== 1'b1) begin
      failures++;
      $display("FAIL branch_wrap addr=%0d redir=%b required addr=4 redir=1", address, ro);
    end
  endtask

  task automatic test_jmp_stall();
    logic ro, re;
    cyc(f_jmp(14), 1'b0, 1'b0, 1'b0, ro, re);
    cyc(f_jmp(12'h005), 1'b0, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd5 || ro !== 1'b1) begin
      failures++;
      $display("FAIL jmp addr=%0d redir=%b required addr=5 redir=1", address, ro);
    end
    cyc(f_jmp(14), 1'b0, 1'b0, 1'b0, ro, re);
    for (int i = 0; i < 3; i++) begin
      cyc(f_jmp(12'h100), 1'b1, 1'b1, 1'b1, ro, re);
      checks++;
      if (address !== 12'd14 || ro !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d addr=%0d redir=%b required addr=14 redir=0", i, address, ro);
      end
    end
    cyc(f_jmp(12'h100), 1'b0, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'h100 || ro !== 1'b1) begin
      failures++;
      $display("FAIL stall_release addr=%h redir=%b required addr=100 redir=1", address, ro);
    end
  endtask

  task automatic test_jsr_ret();
    logic ro, re;
    int exp_a[5];
    logic [18:0] seq_i[5];
    cyc(f_jmp(12'h020), 1'b0, 1'b0, 1'b0, ro, re);
    seq_i = '{f_jsr(12'h100), f_ret(), f_jsr(12'h200), f_jsr(12'h300), f_ret()};
    exp_a = '{12'h100, 12'h021, 12'h200, 12'h300, 12'h201};
    for (int i = 0; i < 5; i++) begin
      cyc(seq_i[i], 1'b0, 1'b0, 1'b0, ro, re);
      checks++;
      if (address !== 12'(exp_a[i]) || ro !== 1'b1 || stack_error !== 1'b0) begin
        failures++;
        $display("FAIL call_return step=%0d addr=%h redir=%b err=%b required addr=%h redir=1 err=0",
                 i, address, ro, stack_error, exp_a[i]);
      end
    end
    cyc(f_ret(), 1'b0, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'h022) begin
      failures++;
      $display("FAIL nested_lifo addr=%h required=022", address);
    end
  endtask

  task automatic test_overflow_underflow();
    logic ro, re;
    int exp_a;
    cyc(f_jmp(0), 1'b0, 1'b0, 1'b0, ro, re);
    for (int i = 0; i < 9; i++) begin
      cyc(f_jsr(12'h400 + i * 16), 1'b0, 1'b0, 1'b0, ro, re);
      checks++;
      if (address !== 12'(12'h400 + i * 16) || stack_error !== (i == 8)) begin
        failures++;
        $display("FAIL jsr_depth call=%0d addr=%h err=%b required addr=%h err=%b",
                 i, address, stack_error, 12'h400 + i * 16, (i == 8));
      end
    end
    for (int k = 1; k <= 8; k++) begin
      exp_a = (k < 8) ? (12'h400 + (7 - k) * 16 + 1) : 1;
      cyc(f_ret(), 1'b0, 1'b0, 1'b0, ro, re);
      checks++;
      if (address !== 12'(exp_a) || stack_error !== 1'b1) begin
        failures++;
        $display("FAIL ret_unwind ret=%0d addr=%h err=%b required addr=%h err=1",
                 k, address, stack_error, exp_a);
      end
    end
    cyc(f_ret(), 1'b0, 1'b0, 1'b0, ro, re);
    checks++;
    if (address !== 12'd2 || ro !== 1'b0 || stack_error !== 1'b1) begin
      failures++;
      $display("FAIL ret_underflow addr=%0d redir=%b err=%b required addr=2 redir=0 err=1",
               address, ro, stack_error);
    end
  endtask

  task automatic test_random();
    logic ro, re;
    logic [18:0] ins;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: ins = 19'($urandom);
        3, 4:    ins = f_br($urandom_range(0, 3), $urandom_range(0, 255));
        5:       ins = f_jmp($urandom_range(0, 4095));
        6, 7:    ins = f_jsr($urandom_range(0, 4095));
        default: ins = f_ret();
      endcase
      cyc(ins, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ro, re);
      checks++;
      if (ro !== re) begin
        failures++;
        $display("FAIL rand_redirect n=%0d actual=%b required=%b", n, ro, re);
      end
      checks++;
      if (address !== 12'(m_pc)) begin
        failures++;
        $display("FAIL rand_address n=%0d actual=%h required=%h", n, address, 12'(m_pc));
      end
      checks++;
      if (stack_error !== m_err) begin
        failures++;
        $display("FAIL rand_stack_error n=%0d actual=%b required=%b", n, stack_error, m_err);
      end
    end
  endtask

  initial begin
    test_reset(1'b0);
    test_sequential();
    test_branches();
    test_wrap();
    test_jmp_stall();
    test_jsr_ret();
    test_overflow_underflow();
    test_reset(1'b1);
    test_random();
    test_reset(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and next-address stage feeding instruction_memory.
- Drives the 12-bit fetch address and receives the 19-bit instruction back combinationally in the same cycle.
- Resolves all control flow locally: conditional branch, JMP, JSR and RET. Uses a hardware return-address stack and flags supplied by the datapath.
- The downstream decoder never redirects the PC.

Parameters:
- ADDR_W, 12, fetch address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 19, instruction width.
- RS_DEPTH, 8, return-stack entries (power of two, 2..16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  high = hold PC and stack this cycle.
- instruction  input  INSTR_W  word read from instruction_memory at address.
- zero_flag  input  1  datapath Z flag, valid during the cycle.
- carry_flag  input  1  datapath C flag, valid during the cycle.
- address  output  ADDR_W  current PC, driven straight from the PC register.
- redirect  output  1  combinational; high when next PC != PC+1 (and stall is low).
- stack_error  output  1  sticky; set on return-stack overflow or underflow.

Behaviour:
- Reset (rst low, asynchronous): PC=0, stack pointer=0, all stack entries=0, stack_error=0. Release is synchronous to clk; first fetch is address 0.
- Latency: one instruction per cycle. The next PC is computed combinationally from the PC, the instruction and the flags, then registered on the edge. There are no bubbles.
- Decode fields (all other encodings are sequential, next PC = PC+1):
  - Branch: instruction[18:16]==3'b101. Condition instruction[15:14]: 00 BZ (Z=1), 01 BNZ (Z=0), 10 BC (C=1), 11 BNC (C=0). Offset instruction[7:0] is two's complement, sign-extended to ADDR_W. Taken: next PC = PC + 1 + offset. Not taken: PC+1.
  - JSR: instruction[18:14]==5'b11100. Push PC+1; next PC = instruction[11:0].
  - JMP: instruction[18:14]==5'b11101. Next PC = instruction[11:0]; bits [13:12] are ignored.
  - RET: instruction[18:14]==5'b11110. Pop; next PC = popped value.
- Arithmetic: all PC sums are modulo 2^ADDR_W.
  - PC 4095 sequential wraps to 0.
  - A taken branch whose target passes 4095 or goes below 0 wraps silently.
- Stall: when stall is high, PC, stack, SP and stack_error all hold, and redirect is forced to 0. The flags and instruction are re-evaluated on the first unstalled cycle.
- Return stack: LIFO, SP counts occupied entries, range 0..RS_DEPTH.
  - Overflow (JSR with SP==RS_DEPTH): the jump still happens, the push is dropped, SP is unchanged, stack_error is set.
  - Underflow (RET with SP==0): next PC = PC+1, SP stays 0, stack_error is set.
- stack_error clears only on reset.
- Reset asserted mid-cycle or mid-stall overrides everything immediately; no pending push or pop survives.
- Flags are ignored for non-branch instructions.

Decomposition:
- fetch_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - Opcode constants: OP_BRANCH=3'b101, OP_JSR=5'b11100, OP_JMP=5'b11101, OP_RET=5'b11110.
  - Enum of branch conditions: COND_Z, COND_NZ, COND_C, COND_NC.
  - A typedef for the decoded control-flow kind: SEQ, BR, JMP, JSR, RET.
- One sub-module, return_stack:
  - Inputs: clk, rst, push, pop, push_data.
  - Outputs: top_data, full, empty.
  - Holds the storage and SP; fetch_unit owns stack_error and all PC logic.

Test Plan:
- Reset and sequential fetch: assert rst low mid-run -> address 0 immediately and stack_error 0. Release with all-zero instructions -> address 0,1,2,3 on successive edges, redirect 0.
- BZ, offset 13, at PC 3: Z=1 -> next address 17, redirect 1. Z=0 -> next address 4. BNC, offset 2, at PC 10: C=0 -> 13; C=1 -> 11.
- Negative offset and wrap: BNZ, offset 8'hFE, at PC 20 with Z=0 -> 19. Sequential at PC 4095 -> 0. BZ, offset 5, at PC 4094 taken -> 4.
- JMP 12'h005 at PC 14 -> 5. Hold stall high for 3 cycles while presenting JMP 12'h100 -> address stays 14 and redirect 0. Release stall -> 0x100.
- JSR 0x100 at PC 0x020, then RET at 0x100 -> 0x021, SP back to 0. Nested JSRs -> return order is LIFO.
- Nine nested JSRs with RS_DEPTH 8 -> 9th jumps but stack_error=1. Eight RETs return correctly; the 9th RET underflows -> PC+1, stack_error stays 1 until reset.
